// File: rtl/mem_map_pkg.sv
`default_nettype none
// =============================================================================
// Module  : mem_map_pkg
// Brief   : Address map, reset instruction and opcode constants for the core.
// Revision: 1.0
// =============================================================================
package mem_map_pkg;

    localparam logic [31:0] IO_BASE    = 32'h8000_0000;
    localparam logic [31:0] LED_ADDR   = IO_BASE + 32'h0000_0000;
    localparam logic [31:0] SW_ADDR    = IO_BASE + 32'h0000_0004;
    localparam logic [31:0] TIMER_ADDR = IO_BASE + 32'h0000_0008;

    localparam logic [31:0] NOP_INSTR  = 32'h0000_0013;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    typedef enum logic [2:0] {
        TGT_NONE  = 3'd0,
        TGT_RAM   = 3'd1,
        TGT_LED   = 3'd2,
        TGT_SW    = 3'd3,
        TGT_TIMER = 3'd4
    } mem_tgt_e;

    // IO words sit at index >= 2^29, so they never collide with any sane RAM depth.
    function automatic mem_tgt_e decode_target(input logic [31:0] word_addr,
                                               input logic [31:0] ram_words);
        if (word_addr < ram_words)                 return TGT_RAM;
        else if (word_addr == (LED_ADDR   >> 2))   return TGT_LED;
        else if (word_addr == (SW_ADDR    >> 2))   return TGT_SW;
        else if (word_addr == (TIMER_ADDR >> 2))   return TGT_TIMER;
        else                                       return TGT_NONE;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sync_2ff.sv
`default_nettype none
// =============================================================================
// Module  : sync_2ff
// Brief   : Two-flop synchroniser for asynchronous board inputs.
// Revision: 1.0
// =============================================================================
module sync_2ff #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule
`default_nettype wire

// File: rtl/mem_unit.sv
`default_nettype none
// =============================================================================
// Module  : mem_unit
// Brief   : Unified RAM + memory-mapped IO, with IR / old PC / data registers.
// Revision: 1.0
// =============================================================================
module mem_unit
    import mem_map_pkg::*;
#(
    parameter int MEM_WORDS = 1024,
    parameter int LED_W     = 16,
    parameter int SW_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      adr,
    input  logic [31:0]      wd,
    input  logic             mem_write,
    input  logic             ir_write,
    input  logic [31:0]      pc,
    input  logic [SW_W-1:0]  sw,
    output logic [31:0]      instr,
    output logic [6:0]       op,
    output logic [31:0]      old_pc,
    output logic [31:0]      data,
    output logic [LED_W-1:0] leds
);

    localparam int AW = $clog2(MEM_WORDS);

    logic [31:0]      word_addr;
    mem_tgt_e         tgt;
    logic [AW-1:0]    ram_idx;
    logic [31:0]      rdata;
    logic [SW_W-1:0]  sw_sync;

    logic [31:0]      ram_q [MEM_WORDS];
    logic [31:0]      instr_q;
    logic [31:0]      old_pc_q;
    logic [31:0]      data_q;
    logic [LED_W-1:0] leds_q;
    logic [31:0]      timer_q;
    logic [31:0]      timer_d;

    assign word_addr = adr >> 2;
    assign tgt       = decode_target(word_addr, 32'(MEM_WORDS));
    assign ram_idx   = word_addr[AW-1:0];

    sync_2ff #(
        .WIDTH (SW_W)
    ) u_sw_sync (
        .clk (clk),
        .rst (rst),
        .d_i (sw),
        .q_o (sw_sync)
    );

    always_comb begin
        rdata = '0;
        case (tgt)
            TGT_RAM:   rdata = ram_q[ram_idx];
            TGT_LED:   rdata = 32'(leds_q);
            TGT_SW:    rdata = 32'(sw_sync);
            TGT_TIMER: rdata = timer_q;
            default:   rdata = '0;
        endcase
    end

    // A store to the timer overrides that cycle's increment.
    always_comb begin
        timer_d = timer_q + 32'd1;
        if (mem_write && (tgt == TGT_TIMER)) begin
            timer_d = wd;
        end
    end

    // RAM has no reset, so a store coinciding with reset is gated explicitly.
    always_ff @(posedge clk) begin
        if (!rst && mem_write && (tgt == TGT_RAM)) begin
            ram_q[ram_idx] <= wd;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instr_q  <= NOP_INSTR;
            old_pc_q <= '0;
            data_q   <= '0;
            leds_q   <= '0;
            timer_q  <= '0;
        end else begin
            data_q  <= rdata;
            timer_q <= timer_d;
            if (ir_write) begin
                instr_q  <= rdata;
                old_pc_q <= pc;
            end
            if (mem_write && (tgt == TGT_LED)) begin
                leds_q <= wd[LED_W-1:0];
            end
        end
    end

    assign instr  = instr_q;
    assign op     = instr_q[6:0];
    assign old_pc = old_pc_q;
    assign data   = data_q;
    assign leds   = leds_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_unit.sv
`default_nettype none
// =============================================================================
// Module  : tb_mem_unit
// Brief   : Directed, self-checking bench for mem_unit with a reference model.
// Revision: 1.0
// =============================================================================
module tb_mem_unit;

    localparam int MEM_WORDS = 1024;
    localparam int LED_W     = 16;
    localparam int SW_W      = 16;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [31:0]      adr = '0;
    logic [31:0]      wd = '0;
    logic             mem_write = 1'b0;
    logic             ir_write = 1'b0;
    logic [31:0]      pc = '0;
    logic [SW_W-1:0]  sw = '0;
    logic [31:0]      instr;
    logic [6:0]       op;
    logic [31:0]      old_pc;
    logic [31:0]      data;
    logic [LED_W-1:0] leds;

    int n_total = 0;
    int n_pass  = 0;

    mem_unit #(
        .MEM_WORDS (MEM_WORDS),
        .LED_W     (LED_W),
        .SW_W      (SW_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .adr       (adr),
        .wd        (wd),
        .mem_write (mem_write),
        .ir_write  (ir_write),
        .pc        (pc),
        .sw        (sw),
        .instr     (instr),
        .op        (op),
        .old_pc    (old_pc),
        .data      (data),
        .leds      (leds)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %08h, expected %08h at %0t", name, act, exp, $time);
    endtask

    // Reference model: memory map as plain arithmetic, RAM as a sparse array.
    logic [31:0] m_ram [int unsigned];
    logic [31:0] m_instr = 32'h13, m_old_pc = 0, m_data = 0, m_timer = 0;
    logic [15:0] m_leds = 0;
    logic [15:0] m_sw_hist [2] = '{16'h0, 16'h0};
    bit          m_instr_ok = 1, m_data_ok = 1;

    function automatic logic [31:0] model_read(input logic [31:0] a, output bit known);
        int unsigned w = a / 4;
        known = 1;
        if (a < MEM_WORDS * 4) begin
            if (m_ram.exists(w)) return m_ram[w];
            known = 0;
            return 0;
        end
        case (a & 32'hFFFF_FFFC)
            32'h8000_0000: return {16'h0, m_leds};
            32'h8000_0004: return {16'h0, m_sw_hist[1]};
            32'h8000_0008: return m_timer;
            default:       return 0;
        endcase
    endfunction

    always @(posedge clk or posedge rst) begin
        logic [31:0] rd;
        bit          ok;
        if (rst) begin
            m_instr = 32'h13; m_instr_ok = 1;
            m_old_pc = 0; m_data = 0; m_data_ok = 1;
            m_leds = 0; m_timer = 0;
            m_sw_hist[0] = 0; m_sw_hist[1] = 0;
        end else begin
            rd = model_read(adr, ok);
            m_data = rd; m_data_ok = ok;
            if (ir_write) begin
                m_instr = rd; m_instr_ok = ok; m_old_pc = pc;
            end
            m_timer = m_timer + 1;
            if (mem_write) begin
                if (adr < MEM_WORDS * 4) m_ram[adr / 4] = wd;
                else if ((adr & 32'hFFFF_FFFC) == 32'h8000_0000) m_leds = wd[15:0];
                else if ((adr & 32'hFFFF_FFFC) == 32'h8000_0008) m_timer = wd;
            end
            m_sw_hist[1] = m_sw_hist[0];
            m_sw_hist[0] = sw;
        end
    end

    always @(negedge clk) begin
        if (m_instr_ok) begin
            chk("model_instr", instr, m_instr);
            chk("model_op", {25'h0, op}, {25'h0, m_instr[6:0]});
        end
        chk("model_old_pc", old_pc, m_old_pc);
        if (m_data_ok) chk("model_data", data, m_data);
        chk("model_leds", {16'h0, leds}, {16'h0, m_leds});
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d);
        adr = a; wd = d; mem_write = 1'b1;
        tick();
        mem_write = 1'b0;
    endtask

    initial begin
        // Reset and NOP
        repeat (3) tick();
        rst = 1'b0;
        chk("reset_instr", instr, 32'h0000_0013);
        chk("reset_op", {25'h0, op}, 32'h13);
        chk("reset_leds", {16'h0, leds}, 32'h0);
        adr = 32'h8000_0008;
        tick();
        chk("timer_after_reset", data, 32'h0);

        // RAM store/load, misaligned read, out-of-range store
        store(32'h0000_0000, 32'h1111_1111);
        store(32'h0000_0010, 32'hDEAD_BEEF);
        adr = 32'h0000_0013;
        tick();
        chk("ram_misaligned_load", data, 32'hDEAD_BEEF);
        store(32'h0000_1000, 32'h1234_5678);
        adr = 32'h0000_1000;
        tick();
        chk("ram_out_of_range", data, 32'h0);
        adr = 32'h0000_0000;
        tick();
        chk("ram_no_alias", data, 32'h1111_1111);

        // Fetch
        store(32'h0000_0008, 32'h0000_006F);
        adr = 32'h8; pc = 32'h8; ir_write = 1'b1;
        tick();
        ir_write = 1'b0;
        chk("fetch_instr", instr, 32'h0000_006F);
        chk("fetch_op", {25'h0, op}, 32'h6F);
        chk("fetch_old_pc", old_pc, 32'h8);
        adr = 32'h10; pc = 32'h40;
        tick(); tick();
        chk("fetch_hold_instr", instr, 32'h0000_006F);
        chk("fetch_hold_old_pc", old_pc, 32'h8);

        // LED and switches
        store(32'h8000_0000, 32'h0001_2345);
        chk("led_write", {16'h0, leds}, 32'h2345);
        adr = 32'h8000_0004; sw = 16'hA5A5;
        tick();
        chk("sw_edge1", data, 32'h0);
        tick();
        chk("sw_edge2", data, 32'h0);
        tick();
        chk("sw_edge3", data, 32'h0000_A5A5);
        store(32'h8000_0004, 32'h0000_FFFF);
        adr = 32'h8000_0004;
        tick();
        chk("sw_write_ignored", data, 32'h0000_A5A5);
        chk("sw_write_leds", {16'h0, leds}, 32'h2345);

        // Timer wrap and write priority
        store(32'h8000_0008, 32'hFFFF_FFFE);
        tick();
        chk("timer_load", data, 32'hFFFF_FFFE);
        tick();
        chk("timer_inc", data, 32'hFFFF_FFFF);
        tick();
        chk("timer_wrap", data, 32'h0);
        store(32'h8000_0008, 32'h5);
        tick();
        chk("timer_reload", data, 32'h5);

        // Simultaneous ir_write and mem_write
        store(32'h0000_0020, 32'hAAAA_0001);
        adr = 32'h20; wd = 32'hBBBB_0002; pc = 32'h20;
        mem_write = 1'b1; ir_write = 1'b1;
        tick();
        mem_write = 1'b0; ir_write = 1'b0;
        chk("both_ir_prewrite", instr, 32'hAAAA_0001);
        tick();
        chk("both_write_commit", data, 32'hBBBB_0002);

        // Reset mid-store
        adr = 32'h0; wd = 32'hCAFE_F00D; mem_write = 1'b1; rst = 1'b1;
        #1;
        chk("async_reset_instr", instr, 32'h0000_0013);
        tick();
        adr = 32'h8000_0000; wd = 32'h0000_FFFF;
        tick();
        rst = 1'b0; mem_write = 1'b0; adr = 32'h0;
        chk("rst_store_leds", {16'h0, leds}, 32'h0);
        chk("rst_store_instr", instr, 32'h0000_0013);
        tick();
        chk("rst_store_ram", data, 32'h1111_1111);

        tick(); tick();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_unit.md
# mem_unit

Unified instruction/data memory and memory-mapped I/O for the multi-cycle core. It decodes the datapath's already-muxed address, reads RAM or I/O, and commits stores. It also owns the non-architectural registers fed by memory: instruction register, old PC and data register. It drives `op` into the main control FSM and consumes that FSM's `mem_write` and `ir_write`.

## Interface
- `MEM_WORDS`, 1024: RAM depth in 32-bit words; power of two.
- `LED_W`, 16: LED register width.
- `SW_W`, 16: switch input width.
- `clk  in  1`: single clock, rising edge.
- `rst  in  1`: asynchronous, active-high reset.
- `adr  in  32`: byte address from the datapath's `adr_src` mux.
- `wd  in  32`: store data.
- `mem_write  in  1`: commit store this cycle.
- `ir_write  in  1`: capture instruction and PC this cycle.
- `pc  in  32`: current PC.
- `sw  in  SW_W`: asynchronous board switches.
- `instr  out  32`: instruction register.
- `op  out  7`: `instr[6:0]`, to the main FSM.
- `old_pc  out  32`: PC of the fetched instruction.
- `data  out  32`: data register.
- `leds  out  LED_W`: LED register.

## Operation
- Word-addressed; `adr[1:0]` ignored for reads and writes.
- Address map:
  - RAM: `adr[31]=0`, word index `adr[31:2] < MEM_WORDS`.
  - LED at 0x8000_0000 (R/W).
  - SW at 0x8000_0004 (R only).
  - TIMER at 0x8000_0008 (R/W).
- Unmapped, including RAM index ≥ MEM_WORDS: read returns 0, write ignored.
- Read path: `rdata` is combinational from `adr`, using asynchronous-read RAM.
  - LED reads are zero-extended.
  - SW reads return the synchronised value, zero-extended.
- Write path: on a rising edge with `mem_write=1`, write the full word `wd` to the decoded target.
  - LED target takes `wd[LED_W-1:0]`.
  - SW target: write ignored.
- `instr`/`old_pc`: on an edge with `ir_write=1`, `instr<=rdata` and `old_pc<=pc`. Otherwise both hold.
- `data`: `data<=rdata` every cycle, unconditionally.
- Timer: 32-bit free-running counter, +1 per cycle, wraps 0xFFFF_FFFF→0. A write loads `wd`; the write wins over the increment that cycle.
- Switches pass through a 2-flop synchroniser before the read mux.

## Timing
- Reset values:
  - `instr` = 0x0000_0013 (NOP), so `op` = 7'b0010011.
  - `old_pc` = 0, `data` = 0, `leds` = 0, timer = 0, synchroniser = 0.
- RAM contents are not reset.
- Reset asserted mid-operation: registers clear immediately. A store on an edge where `rst=1` is dropped, including to RAM.
- Load latency: address valid in cycle N → `data` valid in N+1.
- Fetch: `ir_write` in N → `instr`/`op` valid in N+1, ahead of the FSM's decode state.
- Store visibility: `mem_write` at edge N → read-back valid combinationally from cycle N+1.
- `mem_write` and `ir_write` asserted together (illegal for the FSM, but defined): IR captures pre-write `rdata`; the write still commits.
- Timer reads return the current count. A read in the cycle after a load of X returns X.
- Switch latency: a `sw` change appears in `rdata` after 2 edges.
- No stall or handshake: every access completes in one cycle.

## Structure
- Shared package `mem_map_pkg` holds:
  - `LED_ADDR`, `SW_ADDR`, `TIMER_ADDR`.
  - `IO_BASE` = 0x8000_0000.
  - `NOP_INSTR` = 0x0000_0013.
  - Opcode constants shared with the FSM.
- Sub-module `sync_2ff` (parameterised width) for the switches; reusable for other board inputs.
- RAM is an inferred array in this module. Initialisation is via simulation/synthesis preload, not RTL reset.

## Test plan
- **Reset and NOP.** Assert `rst` for 3 cycles then release → `instr`=0x0000_0013, `op`=0x13, `leds`=0, timer read = 0 in the first cycle after release.
- **RAM store/load with misalignment.** Store 0xDEAD_BEEF at 0x0000_0010, then read 0x0000_0013 → `rdata`=0xDEAD_BEEF, and `data`=0xDEAD_BEEF one cycle later. Store to 0x0000_1000 (index 1024) → ignored, reads 0.
- **Fetch.** Preload RAM[2]=0x0000_006F, `pc`=0x8, pulse `ir_write` → next cycle `instr`=0x0000_006F, `op`=0x6F, `old_pc`=0x8. Hold `ir_write`=0 → unchanged.
- **LED and switches.** Write 0x1_2345 to 0x8000_0000 → `leds`=0x2345. Set `sw`=0xA5A5 → read of 0x8000_0004 returns 0x0000_A5A5 after 2 edges, 0 before. Write to 0x8000_0004 → no effect.
- **Timer wrap and write priority.** Load 0xFFFF_FFFE, then read on consecutive cycles → 0xFFFF_FFFE, 0xFFFF_FFFF, 0x0000_0000. Load 5 while running → next read is 5.
- **Reset mid-store.** Assert `rst` on the same edge as a store to RAM[0] plus an LED write → RAM[0] keeps its old value, `leds`=0, `instr`=NOP.
